// File: rtl/cache_mem_bridge.sv
// Line-transfer engine between the cache data array and a 32-bit main-memory port.
// Serialises an optional 16-beat writeback followed by a 16-beat refill of one block.
module cache_mem_bridge #(
  parameter int unsigned PA_WIDTH   = 32,
  parameter int unsigned MEM_WIDTH  = 32,
  parameter int unsigned BLOCK_SIZE = 512,
  parameter int unsigned BO_WIDTH   = 4,
  parameter int unsigned WO_WIDTH   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wb,
  input  logic [PA_WIDTH-1:0]   req_rd_addr,
  input  logic [PA_WIDTH-1:0]   req_wr_addr,
  input  logic [BLOCK_SIZE-1:0] wb_data,
  output logic [BLOCK_SIZE-1:0] fill_data,
  output logic                  fill_valid,
  output logic                  busy,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [PA_WIDTH-1:0]   mem_addr,
  output logic [MEM_WIDTH-1:0]  mem_wdata,
  input  logic                  mem_gnt,
  input  logic                  mem_rvalid,
  input  logic [MEM_WIDTH-1:0]  mem_rdata
);

  localparam int unsigned OffW      = BO_WIDTH + WO_WIDTH;
  localparam int unsigned BaseW     = PA_WIDTH - OffW;
  localparam int unsigned WordShift = $clog2(MEM_WIDTH);
  localparam logic [BO_WIDTH-1:0] LastBeat = '1;

  typedef enum logic [2:0] {StIdle, StWbReq, StRdReq, StRdWait, StDone} state_e;

  state_e                   state_q, state_d;
  logic [BO_WIDTH-1:0]      cnt_q, cnt_d;
  logic [BaseW-1:0]         rd_base_q, wr_base_q;
  logic [BLOCK_SIZE-1:0]    wb_buf_q, fill_data_q;
  logic [BO_WIDTH+WordShift-1:0] word_lsb;
  logic                     accept;
  logic                     fill_we;

  // Block offset bits of the request addresses are deliberately dropped.
  logic unused_addr;
  assign unused_addr = ^{req_rd_addr[OffW-1:0], req_wr_addr[OffW-1:0]};

  assign word_lsb  = {cnt_q, {WordShift{1'b0}}};
  assign req_ready = rst_n && (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign fill_data = fill_data_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    fill_we    = 1'b0;
    fill_valid = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (req_valid && req_ready) begin
          accept  = 1'b1;
          cnt_d   = '0;
          state_d = req_wb ? StWbReq : StRdReq;
        end
      end
      StWbReq: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {wr_base_q, cnt_q, {WO_WIDTH{1'b0}}};
        mem_wdata = wb_buf_q[word_lsb +: MEM_WIDTH];
        if (mem_gnt) begin
          if (cnt_q == LastBeat) begin
            cnt_d   = '0;
            state_d = StRdReq;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRdReq: begin
        mem_req  = 1'b1;
        mem_addr = {rd_base_q, cnt_q, {WO_WIDTH{1'b0}}};
        if (mem_gnt) state_d = StRdWait;
      end
      StRdWait: begin
        // Address kept on the bus while the single outstanding read returns.
        mem_addr = {rd_base_q, cnt_q, {WO_WIDTH{1'b0}}};
        if (mem_rvalid) begin
          fill_we = 1'b1;
          if (cnt_q == LastBeat) begin
            state_d = StDone;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = StRdReq;
          end
        end
      end
      StDone: begin
        fill_valid = 1'b1;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      rd_base_q   <= '0;
      wr_base_q   <= '0;
      wb_buf_q    <= '0;
      fill_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        rd_base_q <= req_rd_addr[PA_WIDTH-1:OffW];
        wr_base_q <= req_wr_addr[PA_WIDTH-1:OffW];
        wb_buf_q  <= wb_data;
      end
      if (fill_we) fill_data_q[word_lsb +: MEM_WIDTH] <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Directed bench for cache_mem_bridge: a small memory responder checks every beat,
// and each test checks fill_valid timing and the assembled refill block.
module tb_cache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_wb;
  logic [31:0]  req_rd_addr, req_wr_addr;
  logic [511:0] wb_data, fill_data;
  logic         fill_valid, busy;
  logic         mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0]  mem_addr, mem_wdata, mem_rdata;

  cache_mem_bridge dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wb     (req_wb),
    .req_rd_addr(req_rd_addr),
    .req_wr_addr(req_wr_addr),
    .wb_data    (wb_data),
    .fill_data  (fill_data),
    .fill_valid (fill_valid),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Memory responder state and expectations for the current transfer.
  int          cyc = 0, abs_cyc = 0, n_acc = 0, last_acc = 0, prev_acc = 0;
  int          wi = 0, ri = 0, fv_count = 0, fv_cycle = 0;
  int          rd_delay = 1, rd_wait = 0;
  int          stall_start = 0, stall_len = 0, spur_cyc = 0;
  logic        exp_wb = 1'b0;
  logic [31:0] exp_rd_base = '0, exp_wr_base = '0, pend = '0, m_addr, m_wdata;
  logic        m_acc, m_hs_wr, m_hs_rd;

  function automatic logic in_stall(input int c);
    return stall_len > 0 && c >= stall_start && c < stall_start + stall_len;
  endfunction

  always @(posedge clk) begin
    m_acc   = req_valid && req_ready;
    m_hs_wr = mem_req && mem_we && mem_gnt;
    m_hs_rd = mem_req && !mem_we && mem_gnt;
    m_addr  = mem_addr;
    m_wdata = mem_wdata;
    abs_cyc++;
    if (m_acc) begin
      n_acc++;
      prev_acc = last_acc;
      last_acc = abs_cyc;
      cyc = 0;
      wi  = 0;
      ri  = 0;
    end
    if (m_hs_wr) begin
      check_eq("wb_addr", m_addr, exp_wr_base + 32'(4 * wi));
      check_eq("wb_data", m_wdata, 32'h100 + 32'(wi));
      wi++;
    end
    if (m_hs_rd) begin
      check_eq("rd_addr", m_addr, exp_rd_base + 32'(4 * ri));
      check_eq("rd_after_wb", wi, exp_wb ? 16 : 0);
      ri++;
      rd_wait = rd_delay;
      pend    = 32'hA000_0000 + {28'd0, m_addr[5:2]};
    end
    #1;
    cyc++;
    mem_gnt    = !in_stall(cyc);
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    if (!rst_n) begin
      rd_wait = 0;
    end else if (rd_wait > 0) begin
      rd_wait--;
      if (rd_wait == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pend;
      end
    end
    if (spur_cyc != 0 && cyc == spur_cyc) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
    end
    if (fill_valid) begin
      fv_count++;
      fv_cycle = cyc;
    end
    if (in_stall(cyc)) begin
      check_eq("stall_req", mem_req, 1'b1);
      check_eq("stall_addr", mem_addr, exp_wr_base + 32'h14);
      check_eq("stall_wdata", mem_wdata, 32'h105);
    end
  end

  task automatic setup_req(input logic wb, input logic [31:0] rd_a, input logic [31:0] wr_a);
    @(negedge clk);
    req_wb      = wb;
    req_rd_addr = rd_a;
    req_wr_addr = wr_a;
    exp_wb      = wb;
    exp_rd_base = rd_a & ~32'h3F;
    exp_wr_base = wr_a & ~32'h3F;
    fv_count    = 0;
    req_valid   = 1'b1;
  endtask

  task automatic wait_fill(input string tag, input int target);
    for (int k = 0; k < 300 && fv_count < target; k++) begin
      @(posedge clk);
      #2;
    end
    check_eq({tag, "_fill_seen"}, fv_count >= target, 1'b1);
  endtask

  task automatic do_req(input string tag, input logic wb, input logic [31:0] rd_a,
                        input logic [31:0] wr_a, input int exp_fv);
    setup_req(wb, rd_a, wr_a);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    check_eq({tag, "_busy"}, busy, 1'b1);
    check_eq({tag, "_ready_low"}, req_ready, 1'b0);
    wait_fill(tag, 1);
    check_eq({tag, "_fv_cycle"}, fv_cycle, exp_fv);
    repeat (3) @(posedge clk);
    #2;
    check_eq({tag, "_fv_once"}, fv_count, 1);
    check_eq({tag, "_reads"}, ri, 16);
    check_eq({tag, "_writes"}, wi, wb ? 16 : 0);
    check_eq({tag, "_idle"}, busy, 1'b0);
    for (int i = 0; i < 16; i++)
      check_eq({tag, "_fill_word"}, fill_data[32*i +: 32], 32'hA000_0000 + 32'(i));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst_n = 1'b0; req_valid = 1'b0; req_wb = 1'b0;
    req_rd_addr = '0; req_wr_addr = '0; wb_data = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b0; mem_rdata = '0;
    for (int i = 0; i < 16; i++) wb_data[32*i +: 32] = 32'h100 + 32'(i);
    repeat (3) @(posedge clk);
    #2;
    check_eq("rst_ready", req_ready, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_mem_req", mem_req, 1'b0);
    check_eq("rst_mem_we", mem_we, 1'b0);
    check_eq("rst_mem_addr", mem_addr, 32'h0);
    check_eq("rst_mem_wdata", mem_wdata, 32'h0);
    check_eq("rst_fill_valid", fill_valid, 1'b0);
    check_eq("rst_fill_data", |fill_data, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready", req_ready, 1'b1);

    do_req("clean", 1'b0, 32'h0000_1234, 32'h0, 33);
    do_req("dirty", 1'b1, 32'h0000_2000, 32'h0004_0040, 49);

    stall_start = 6; stall_len = 3;
    do_req("stall", 1'b1, 32'h0000_2000, 32'h0004_0040, 52);
    stall_len = 0;

    rd_delay = 4; spur_cyc = 6;
    do_req("rdelay", 1'b0, 32'h0000_1234, 32'h0, 81);
    rd_delay = 1; spur_cyc = 0;

    // Abort during read beat 7, which is issued in cycle 15.
    setup_req(1'b0, 32'h0000_1234, 32'h0);
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    for (int k = 0; k < 100 && cyc != 15; k++) begin
      @(posedge clk);
      #2;
    end
    check_eq("abort_beat7_addr", mem_addr, 32'h0000_121C);
    check_eq("abort_beat7_req", mem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("abort_mem_req", mem_req, 1'b0);
    check_eq("abort_busy", busy, 1'b0);
    check_eq("abort_fill_data", |fill_data, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_eq("abort_ready", req_ready, 1'b1);
    do_req("restart", 1'b0, 32'h0000_3000, 32'h0, 33);

    // Back-to-back with req_valid held high across both transfers.
    n0 = n_acc;
    setup_req(1'b0, 32'h0000_1234, 32'h0);
    wait_fill("b2b", 2);
    req_valid = 1'b0;
    check_eq("b2b_accepts", n_acc - n0, 2);
    check_eq("b2b_gap", last_acc - prev_acc, 34);
    repeat (4) @(posedge clk);
    #2;
    check_eq("b2b_fv_count", fv_count, 2);
    check_eq("b2b_no_third", n_acc - n0, 2);
    check_eq("b2b_idle", busy, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
